// File: rtl/alarm_mode_ctrl_if.sv
// Signal bundle between alarm_mode_ctrl and the debouncers/datapaths around it.
// master = surrounding system, slave = the mode controller.
interface alarm_mode_ctrl_if #(
    parameter int NUM_ALARMS = 4,
    parameter int DIGITS     = 4,
    parameter int LED_W      = 16
);
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic                           tick_1hz;
    logic [3:0]                     sw;
    logic                           btn_ack;
    logic                           btn_snooze;
    logic [4*DIGITS-1:0]            cur_time;
    logic [NUM_ALARMS*4*DIGITS-1:0] alarm_time;
    logic [NUM_ALARMS-1:0]          alarm_en;
    logic [2:0]                     cursor;
    logic [3:0]                     random_led;
    logic                           game_led_off;
    logic                           game_done;

    logic                           en_time_set;
    logic                           en_alarm_set;
    logic                           en_stopwatch;
    logic                           en_alarm_on;
    logic                           en_game;
    logic [IDX_W-1:0]               ring_idx;
    logic [NUM_ALARMS-1:0]          missed;
    logic [LED_W-1:0]               led;
    logic [DIGITS-1:0]              blink_state;

    modport master (
        output tick_1hz, sw, btn_ack, btn_snooze, cur_time, alarm_time, alarm_en,
               cursor, random_led, game_led_off, game_done,
        input  en_time_set, en_alarm_set, en_stopwatch, en_alarm_on, en_game,
               ring_idx, missed, led, blink_state
    );

    modport slave (
        input  tick_1hz, sw, btn_ack, btn_snooze, cur_time, alarm_time, alarm_en,
               cursor, random_led, game_led_off, game_done,
        output en_time_set, en_alarm_set, en_stopwatch, en_alarm_on, en_game,
               ring_idx, missed, led, blink_state
    );
endinterface

// File: rtl/alarm_mode_ctrl.sv
// User-mode arbiter with NUM_ALARMS alarm slots, ring timeout and heartbeat LED.
// Define ALARM_SNOOZE_EN to build the snooze state and its countdown.
module alarm_mode_ctrl #(
    parameter int NUM_ALARMS   = 4,
    parameter int DIGITS       = 4,
    parameter int LED_W        = 16,
    parameter int BLINK_DIV    = 50_000_000,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300
) (
    input logic              clk,
    input logic              reset,
    alarm_mode_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int TW    = 4 * DIGITS;
    localparam int LW1   = LED_W - 1;
    localparam int BD_W  = $clog2(BLINK_DIV + 1);
    localparam int RC_W  = $clog2(RING_TIMEOUT + 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SC_W = $clog2(SNOOZE_SEC + 1);
    typedef enum logic [2:0] {IDLE, TSET, ASET, SWATCH, ARMED, RING, SNOOZE, GAME} state_t;
    logic [SC_W-1:0] snz_q, snz_nx;
`else
    typedef enum logic [2:0] {IDLE, TSET, ASET, SWATCH, ARMED, RING, GAME} state_t;
    logic unused_snooze;
    assign unused_snooze = bus.btn_snooze;
`endif

    state_t                state_q, state_nx, back;
    logic [NUM_ALARMS-1:0] match, match_q, rise, en_q, missed_q, missed_nx;
    logic                  hit, timeout, alarm_on;
    logic [IDX_W-1:0]      hit_idx, idx_q, idx_nx;
    logic [RC_W-1:0]       ring_cnt_q, ring_cnt_nx;
    logic [BD_W-1:0]       blink_cnt;
    logic                  hb_q, hb_nx, blink_wrap;
    logic [LW1-1:0]        led_lo;
    logic [DIGITS-1:0]     blink_nx, cur_mask;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++)
            match[i] = bus.alarm_en[i] && (bus.alarm_time[i*TW +: TW] == bus.cur_time);
    end

    // Edge detect against last cycle's match; history updates in every state.
    assign rise = match & ~match_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (rise[i] && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign blink_wrap = (blink_cnt == BD_W'(BLINK_DIV - 1));
    assign hb_nx      = hb_q ^ blink_wrap;

    always_comb begin
        state_nx    = state_q;
        idx_nx      = idx_q;
        ring_cnt_nx = ring_cnt_q;
        timeout     = 1'b0;
        back        = bus.sw[3] ? ARMED : IDLE;
`ifdef ALARM_SNOOZE_EN
        snz_nx      = snz_q;
`endif
        case (state_q)
            IDLE: begin
                if      (bus.sw[0]) state_nx = TSET;
                else if (bus.sw[1]) state_nx = ASET;
                else if (bus.sw[2]) state_nx = SWATCH;
                else if (bus.sw[3]) state_nx = ARMED;
            end
            TSET:   if (!bus.sw[0]) state_nx = back;
            ASET:   if (!bus.sw[1]) state_nx = back;
            SWATCH: if (!bus.sw[2]) state_nx = back;
            ARMED: begin
                if (!bus.sw[3]) state_nx = IDLE;
                else if (hit) begin
                    state_nx    = RING;
                    idx_nx      = hit_idx;
                    ring_cnt_nx = '0;
                end
            end
            RING: begin
                if (bus.btn_ack) state_nx = GAME;
`ifdef ALARM_SNOOZE_EN
                else if (bus.btn_snooze) begin
                    state_nx = SNOOZE;
                    snz_nx   = SC_W'(SNOOZE_SEC);
                end
`endif
                else if (bus.tick_1hz) begin
                    if (ring_cnt_q == RC_W'(RING_TIMEOUT - 1)) begin
                        timeout  = 1'b1;
                        state_nx = back;
                    end else begin
                        ring_cnt_nx = ring_cnt_q + RC_W'(1);
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (!bus.sw[3]) state_nx = IDLE;
                else if (snz_q == '0 || (bus.tick_1hz && snz_q == SC_W'(1))) begin
                    state_nx    = RING;
                    ring_cnt_nx = '0;
                end else if (bus.tick_1hz) begin
                    snz_nx = snz_q - SC_W'(1);
                end
            end
`endif
            GAME:    if (bus.game_done) state_nx = back;
            default: state_nx = IDLE;
        endcase
    end

    // A disable falling edge clears the flag even if a timeout sets it the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_ALARMS; i++)
            missed_nx[i] = (missed_q[i] || (timeout && idx_q == IDX_W'(i)))
                           && !(en_q[i] && !bus.alarm_en[i]);
    end

    always_comb begin
        led_lo   = '0;
        blink_nx = '0;
        cur_mask = '0;
        if (bus.cursor != 3'd0 && int'(bus.cursor) <= DIGITS)
            cur_mask = DIGITS'(1) << (bus.cursor - 3'd1);
        case (state_nx)
            TSET:   begin led_lo[0] = 1'b1; blink_nx = cur_mask; end
            ASET:   begin led_lo[1] = 1'b1; blink_nx = cur_mask; end
            SWATCH: led_lo[2] = 1'b1;
            RING:   begin led_lo = hb_nx ? '0 : '1; blink_nx = '1; end
            GAME:   if (int'(bus.random_led) < LW1 && !bus.game_led_off)
                        led_lo = LW1'(1) << bus.random_led;
            default: ;
        endcase
        alarm_on = (state_nx == ARMED) || (state_nx == RING);
`ifdef ALARM_SNOOZE_EN
        alarm_on = alarm_on || (state_nx == SNOOZE);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            match_q          <= '0;
            en_q             <= '0;
            missed_q         <= '0;
            idx_q            <= '0;
            ring_cnt_q       <= '0;
            blink_cnt        <= '0;
            hb_q             <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_q            <= '0;
`endif
            bus.en_time_set  <= 1'b0;
            bus.en_alarm_set <= 1'b0;
            bus.en_stopwatch <= 1'b0;
            bus.en_alarm_on  <= 1'b0;
            bus.en_game      <= 1'b0;
            bus.led          <= '0;
            bus.blink_state  <= '0;
        end else begin
            state_q          <= state_nx;
            match_q          <= match;
            en_q             <= bus.alarm_en;
            missed_q         <= missed_nx;
            idx_q            <= idx_nx;
            ring_cnt_q       <= ring_cnt_nx;
            blink_cnt        <= blink_wrap ? '0 : blink_cnt + BD_W'(1);
            hb_q             <= hb_nx;
`ifdef ALARM_SNOOZE_EN
            snz_q            <= snz_nx;
`endif
            bus.en_time_set  <= (state_nx == TSET);
            bus.en_alarm_set <= (state_nx == ASET);
            bus.en_stopwatch <= (state_nx == SWATCH);
            bus.en_alarm_on  <= alarm_on;
            bus.en_game      <= (state_nx == GAME);
            bus.led          <= {hb_nx, led_lo};
            bus.blink_state  <= blink_nx;
        end
    end

    assign bus.ring_idx = idx_q;
    assign bus.missed   = missed_q;
endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: vector table, directed corner sequences and random
// stimulus checked every cycle against a mode-level reference model.
module tb_alarm_mode_ctrl;
    localparam int NA = 4, DG = 4, LW = 16, BD = 5, RT = 3, SS = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    localparam int M_IDLE = 0, M_TSET = 1, M_ASET = 2, M_SW = 3,
                   M_ARMED = 4, M_RING = 5, M_SNOOZE = 6, M_GAME = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alarm_mode_ctrl_if #(.NUM_ALARMS(NA), .DIGITS(DG), .LED_W(LW)) bus ();

    alarm_mode_ctrl #(
        .NUM_ALARMS(NA), .DIGITS(DG), .LED_W(LW),
        .BLINK_DIV(BD), .RING_TIMEOUT(RT), .SNOOZE_SEC(SS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total, bad;

    // Reference model: mode as a plain number, seconds counted up/down as ints.
    int            m_mode, m_idx, m_secs, m_left, m_edges;
    logic [NA-1:0] m_missed, m_prev, m_prev_en;
    logic [4:0]    e_en;
    logic [LW-1:0] e_led;
    logic [DG-1:0] e_blink;

    typedef struct {
        logic [3:0]    sw;
        logic [2:0]    cursor;
        logic [4:0]    en;
        logic [LW-2:0] led;
        logic [DG-1:0] blink;
    } vec_t;
    vec_t tbl[9];
    logic [15:0] times[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_en();
        return {bus.en_game, bus.en_alarm_on, bus.en_stopwatch, bus.en_alarm_set, bus.en_time_set};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idx = 0; m_secs = 0; m_left = 0; m_edges = 0;
        m_missed = '0; m_prev = '0; m_prev_en = '0;
        e_en = '0; e_led = '0; e_blink = '0;
    endfunction

    function automatic void model_step();
        logic [NA-1:0] mt, rs;
        int nm, back, rl;
        bit hb;
        for (int i = 0; i < NA; i++)
            mt[i] = bus.alarm_en[i] && (bus.alarm_time[i*4*DG +: 4*DG] == bus.cur_time);
        rs   = mt & ~m_prev;
        back = bus.sw[3] ? M_ARMED : M_IDLE;
        nm   = m_mode;
        case (m_mode)
            M_IDLE:  nm = bus.sw[0] ? M_TSET : bus.sw[1] ? M_ASET : bus.sw[2] ? M_SW :
                          bus.sw[3] ? M_ARMED : M_IDLE;
            M_TSET:  if (!bus.sw[0]) nm = back;
            M_ASET:  if (!bus.sw[1]) nm = back;
            M_SW:    if (!bus.sw[2]) nm = back;
            M_ARMED: if (!bus.sw[3]) nm = M_IDLE;
                     else if (rs != '0) begin
                         nm = M_RING; m_secs = 0;
                         for (int i = NA - 1; i >= 0; i--) if (rs[i]) m_idx = i;
                     end
            M_RING:  if (bus.btn_ack) nm = M_GAME;
                     else if (SNZ && bus.btn_snooze) begin nm = M_SNOOZE; m_left = SS; end
                     else if (bus.tick_1hz) begin
                         m_secs++;
                         if (m_secs == RT) begin m_missed[m_idx] = 1'b1; nm = back; end
                     end
            M_SNOOZE: if (!bus.sw[3]) nm = M_IDLE;
                      else if (bus.tick_1hz) begin
                          m_left--;
                          if (m_left == 0) begin nm = M_RING; m_secs = 0; end
                      end
            M_GAME:  if (bus.game_done) nm = back;
            default: nm = M_IDLE;
        endcase
        for (int i = 0; i < NA; i++) if (m_prev_en[i] && !bus.alarm_en[i]) m_missed[i] = 1'b0;
        m_prev = mt; m_prev_en = bus.alarm_en; m_mode = nm; m_edges++;

        hb = ((m_edges / BD) % 2) == 1;
        e_led = '0; e_led[LW-1] = hb; e_blink = '0; e_en = '0;
        rl = int'(bus.random_led);
        case (m_mode)
            M_TSET:  begin e_led[0] = 1'b1; e_en = 5'b00001; end
            M_ASET:  begin e_led[1] = 1'b1; e_en = 5'b00010; end
            M_SW:    begin e_led[2] = 1'b1; e_en = 5'b00100; end
            M_ARMED, M_SNOOZE: e_en = 5'b01000;
            M_RING:  begin
                if (!hb) for (int i = 0; i < LW - 1; i++) e_led[i] = 1'b1;
                e_blink = '1; e_en = 5'b01000;
            end
            M_GAME:  begin
                if (rl < LW - 1 && !bus.game_led_off) e_led[rl] = 1'b1;
                e_en = 5'b10000;
            end
            default: ;
        endcase
        if ((m_mode == M_TSET || m_mode == M_ASET) && bus.cursor >= 1 && bus.cursor <= DG)
            e_blink[bus.cursor - 1] = 1'b1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("m_en", dut_en(), e_en);
        check("m_ring_idx", bus.ring_idx, m_idx);
        check("m_missed", bus.missed, m_missed);
        check("m_led", bus.led, e_led);
        check("m_blink", bus.blink_state, e_blink);
    endtask

    task automatic pulse_tick();
        bus.tick_1hz = 1'b1; cycle(); bus.tick_1hz = 1'b0;
    endtask

    task automatic ring_on();
        bus.cur_time = 16'h0000; cycle();
        bus.cur_time = 16'h0730; cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, dut_en(), 5'd0);
        check({tag, "_idx"}, bus.ring_idx, 0);
        check({tag, "_missed"}, bus.missed, 0);
        check({tag, "_led"}, bus.led, 0);
        check({tag, "_blink"}, bus.blink_state, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        times = '{16'h0000, 16'h0730, 16'h1200, 16'h0915};
        reset = 1'b1;
        bus.tick_1hz = 0; bus.sw = 0; bus.btn_ack = 0; bus.btn_snooze = 0;
        bus.cur_time = 0; bus.alarm_time = {16'h0915, 16'h0730, 16'h0730, 16'h1200};
        bus.alarm_en = 0; bus.cursor = 0; bus.random_led = 0; bus.game_led_off = 0;
        bus.game_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1 check_all_zero("reset");

        tbl[0] = '{4'b0001, 3'd1, 5'b00001, 15'h0001, 4'b0001};
        tbl[1] = '{4'b0011, 3'd4, 5'b00001, 15'h0001, 4'b1000};
        tbl[2] = '{4'b0110, 3'd3, 5'b00010, 15'h0002, 4'b0100};
        tbl[3] = '{4'b1110, 3'd5, 5'b00010, 15'h0002, 4'b0000};
        tbl[4] = '{4'b0100, 3'd0, 5'b00100, 15'h0004, 4'b0000};
        tbl[5] = '{4'b1100, 3'd2, 5'b00100, 15'h0004, 4'b0000};
        tbl[6] = '{4'b1000, 3'd1, 5'b01000, 15'h0000, 4'b0000};
        tbl[7] = '{4'b0000, 3'd1, 5'b00000, 15'h0000, 4'b0000};
        tbl[8] = '{4'b1011, 3'd0, 5'b00001, 15'h0001, 4'b0000};
        for (int k = 0; k < 9; k++) begin
            bus.sw = 4'b0000; cycle();
            bus.sw = tbl[k].sw; bus.cursor = tbl[k].cursor; cycle();
            check("tbl_en", dut_en(), tbl[k].en);
            check("tbl_led", bus.led[LW-2:0], tbl[k].led);
            check("tbl_blink", bus.blink_state, tbl[k].blink);
        end

        // Time set dropped with sw[3] low passes through IDLE before alarm set.
        bus.sw = 4'b0000; bus.cursor = 0; cycle();
        bus.sw = 4'b0011; cycle();
        check("tset_en", dut_en(), 5'b00001);
        check("tset_led", bus.led[LW-2:0], 15'h0001);
        bus.sw = 4'b0010; cycle();
        check("tset_exit_idle", dut_en(), 5'b00000);
        cycle();
        check("aset_en", dut_en(), 5'b00010);
        bus.sw = 4'b1000; cycle();
        check("aset_to_armed", dut_en(), 5'b01000);

        // Two slots match together: lowest index rings; persisting match never retriggers.
        bus.alarm_en = 4'b0110; cycle();
        bus.cur_time = 16'h0730; cycle();
        check("ring_blink", bus.blink_state, 4'b1111);
        check("ring_idx", bus.ring_idx, 1);
        bus.btn_ack = 1; cycle(); bus.btn_ack = 0;
        check("game_en", dut_en(), 5'b10000);
        bus.random_led = 5; cycle();
        check("game_led5", bus.led[LW-2:0], 15'h0020);
        bus.random_led = 15; cycle();
        check("game_led15", bus.led[LW-2:0], 15'h0000);
        bus.random_led = 5; bus.game_led_off = 1; cycle();
        check("game_led_off", bus.led[LW-2:0], 15'h0000);
        bus.game_led_off = 0; bus.game_done = 1; cycle(); bus.game_done = 0;
        check("game_done_armed", dut_en(), 5'b01000);
        repeat (3) cycle();
        check("no_retrigger_en", dut_en(), 5'b01000);
        check("no_retrigger_blink", bus.blink_state, 4'b0000);

        // Timeout; the tick on the entry cycle is consumed by the counter load.
        bus.cur_time = 16'h0000; cycle();
        bus.cur_time = 16'h0730; bus.tick_1hz = 1; cycle(); bus.tick_1hz = 0;
        check("to_ring", bus.blink_state, 4'b1111);
        pulse_tick(); pulse_tick(); cycle();
        check("to_still_ring", bus.blink_state, 4'b1111);
        check("to_not_missed", bus.missed, 4'b0000);
        pulse_tick();
        check("to_armed", dut_en(), 5'b01000);
        check("to_blink", bus.blink_state, 4'b0000);
        check("to_missed", bus.missed, 4'b0010);
        bus.alarm_en = 4'b0100; cycle();
        check("missed_clear", bus.missed, 4'b0000);

        ring_on();
        check("ring2_idx", bus.ring_idx, 2);
`ifdef ALARM_SNOOZE_EN
        bus.btn_snooze = 1; cycle(); bus.btn_snooze = 0;
        check("snz_led", bus.led[LW-2:0], 15'h0000);
        check("snz_blink", bus.blink_state, 4'b0000);
        pulse_tick();
        check("snz_wait", bus.blink_state, 4'b0000);
        pulse_tick();
        check("snz_back_ring", bus.blink_state, 4'b1111);
        check("snz_idx", bus.ring_idx, 2);
        bus.btn_ack = 1; bus.btn_snooze = 1; cycle(); bus.btn_ack = 0; bus.btn_snooze = 0;
        check("ack_wins", dut_en(), 5'b10000);
`else
        bus.btn_snooze = 1; cycle(); bus.btn_snooze = 0;
        check("snz_ignored", bus.blink_state, 4'b1111);
        bus.btn_ack = 1; cycle(); bus.btn_ack = 0;
        check("ack_game", dut_en(), 5'b10000);
`endif
        bus.game_done = 1; cycle(); bus.game_done = 0;
        check("back_armed", dut_en(), 5'b01000);

        // Async reset in the middle of ringing/snoozing, with a missed flag set.
        ring_on(); pulse_tick(); pulse_tick(); pulse_tick();
        check("missed2", bus.missed, 4'b0100);
        ring_on();
`ifdef ALARM_SNOOZE_EN
        bus.btn_snooze = 1; cycle(); bus.btn_snooze = 0;
`endif
        cycle();
        @(posedge clk); #2 reset = 1'b1; bus.sw = 4'b0000;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk); reset = 1'b0;
        cycle();
        check("post_rst_idle", dut_en(), 5'b00000);

        // Random stimulus against the model.
        bus.alarm_en = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0)
                bus.sw = ($urandom_range(0, 9) < 6) ? 4'b1000 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.cur_time = times[$urandom_range(0, 3)];
            if ($urandom_range(0, 49) == 0) bus.alarm_en = 4'($urandom);
            bus.tick_1hz     = ($urandom_range(0, 3) == 0);
            bus.btn_ack      = ($urandom_range(0, 19) == 0);
            bus.btn_snooze   = ($urandom_range(0, 14) == 0);
            bus.game_done    = ($urandom_range(0, 9) == 0);
            bus.random_led   = 4'($urandom);
            bus.game_led_off = ($urandom_range(0, 3) == 0);
            bus.cursor       = 3'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
